wb_merge: RTL and testbench
===========================

WB_MERGE -- requirements
Module: wb_merge

Interface
REQ-001 Parameter RS, default 5, register-index width.
REQ-002 Parameter RD, default 32, data width.
REQ-003 Parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 in0_valid, in0_ready  in/out  1  lane-0 writeback handshake.
REQ-007 in0_rd  input  RS  lane-0 destination; in0_wd  input  RD  lane-0 data.
REQ-008 in1_valid, in1_ready  in/out  1  lane-1 writeback handshake.
REQ-009 in1_rd  input  RS  lane-1 destination; in1_wd  input  RD  lane-1 data.
REQ-010 wr_en  output  1  register-file write enable.
REQ-011 wr_rd  output  RS, wr_wd  output  RD  register-file write index/data.
REQ-012 byp_rs1, byp_rs2  input  RS  pending-write lookup indices.
REQ-013 byp_hit1, byp_hit2  output  1; byp_data1, byp_data2  output  RD  lookup results.
REQ-014 count  output  log2(DEPTH)+1  occupancy; full, empty  output  1.

Function
REQ-015 Block SHALL merge two writeback lanes into one register-file write port through a circular FIFO of DEPTH {rd, wd} entries.
REQ-016 free = DEPTH - count, taken from registered state at cycle start; pops in the same cycle SHALL NOT add space.
REQ-017 in0_ready SHALL be (free >= 1).
REQ-018 in1_ready SHALL be (free >= 2) or (free >= 1 and !in0_valid).
REQ-019 A lane fires when valid and ready are both high; non-firing lanes SHALL leave state unchanged and the producer holds its data.
REQ-020 A fire with rd == 0 SHALL be discarded: handshake completes, nothing enqueued.
REQ-021 Both lanes firing with nonzero rd SHALL enqueue lane 0 first, then lane 1 (program order).
REQ-022 wr_en SHALL be !empty; wr_rd/wr_wd SHALL be the head entry, and all-zero when empty.
REQ-023 Head SHALL pop every cycle wr_en is high; the register file never back-pressures.
REQ-024 Latency: entry accepted at edge N SHALL drive wr_en no earlier than cycle N+1; no input-to-wr combinational path.
REQ-025 Push and pop in the same cycle SHALL be legal; count_next = count + pushes - pop, pushes in {0,1,2}.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH.
REQ-027 full = (count == DEPTH); empty = (count == 0); count SHALL never exceed DEPTH.
REQ-028 byp_hitN SHALL be high iff byp_rsN != 0 and some valid queued entry has rd == byp_rsN.
REQ-029 byp_dataN SHALL be wd of the youngest matching entry on hit, else 0.
REQ-030 Bypass SHALL search registered queue contents only, excluding same-cycle incoming lanes.
REQ-031 Duplicate rd entries SHALL all be retired in order; none merged or dropped.

Reset
REQ-032 While rst is low at a rising edge: pointers and count SHALL become 0; wr_en, wr_rd, wr_wd, byp_hit*, byp_data* 0; empty 1; full 0.
REQ-033 Reset SHALL override same-cycle fires; queued entries SHALL be lost and SHALL NOT appear on wr_* after reset.
REQ-034 in0_ready and in1_ready SHALL be low while rst is low.

Verification
REQ-035 Single write: after reset, in0 {rd=5, wd=0xDEADBEEF} one cycle -> next cycle wr_en=1, wr_rd=5, wr_wd=0xDEADBEEF; following cycle wr_en=0, count=0.
REQ-036 Dual issue: in0 {3,0x11} and in1 {3,0x22} same cycle -> wr order (3,0x11) then (3,0x22); byp_rs1=3 in cycle after push gives hit1=1, data1=0x22.
REQ-037 x0 discard: in0 {rd=0, wd=0xFFFF} and in1 {rd=7, wd=0x7} -> exactly one write (7,0x7); byp_rs2=0 never hits.
REQ-038 Backpressure/wrap: hold both lanes valid for 8 cycles, DEPTH=4 -> count never >4, in1_ready low whenever free<2 with in0_valid high, all accepted entries retire in acceptance order across pointer wrap.
REQ-039 Reset mid-operation: fill 3 entries, drop rst for one edge while in0 valid -> count=0, wr_en=0 next cycle, no stale entry ever written.
REQ-040 Free==1 corner: count=3, in0_valid=0, in1_valid=1 -> in1_ready=1, count=3 after edge (push+pop).

Source files
------------

// File: rtl/wb_merge_if.sv
// wb_merge_if: bundle of the two writeback lanes, register-file write port, bypass lookups and occupancy
// Ports: master = producer/consumer side (drives lanes and lookup indices),
//        slave  = wb_merge side (drives readies, write port, lookup results, count/full/empty)
interface wb_merge_if #(
    parameter int RS    = 5,
    parameter int RD    = 32,
    parameter int DEPTH = 4
);
    logic                     in0_valid, in0_ready, in1_valid, in1_ready;
    logic [RS-1:0]            in0_rd, in1_rd, wr_rd, byp_rs1, byp_rs2;
    logic [RD-1:0]            in0_wd, in1_wd, wr_wd, byp_data1, byp_data2;
    logic                     wr_en, byp_hit1, byp_hit2, full, empty;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in0_valid, in0_rd, in0_wd, in1_valid, in1_rd, in1_wd, byp_rs1, byp_rs2,
        input  in0_ready, in1_ready, wr_en, wr_rd, wr_wd,
        input  byp_hit1, byp_hit2, byp_data1, byp_data2, count, full, empty
    );
    modport slave (
        input  in0_valid, in0_rd, in0_wd, in1_valid, in1_rd, in1_wd, byp_rs1, byp_rs2,
        output in0_ready, in1_ready, wr_en, wr_rd, wr_wd,
        output byp_hit1, byp_hit2, byp_data1, byp_data2, count, full, empty
    );
endinterface

// File: rtl/wb_merge.sv
// wb_merge: merges two writeback lanes into one register-file write port through a circular FIFO
// Ports: clk, rst (synchronous, active-low); bus (wb_merge_if.slave) carrying lane 0/1 handshakes,
//        the register-file write port (wr_en/wr_rd/wr_wd), two pending-write bypass lookups,
//        and occupancy count/full/empty.
module wb_merge #(
    parameter int RS    = 5,
    parameter int RD    = 32,
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    wb_merge_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [RS-1:0] rd_q [DEPTH];
    logic [RS-1:0] rd_d [DEPTH];
    logic [RD-1:0] wd_q [DEPTH];
    logic [RD-1:0] wd_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, idx;
    logic [CW-1:0] count_q, count_d, free;
    logic          push0, push1, pop;
    logic [1:0]    npush;

    always_comb begin
        // space comes only from registered occupancy; a same-cycle pop never frees a slot
        free = CW'(DEPTH) - count_q;
        bus.in0_ready = rst && free >= CW'(1);
        bus.in1_ready = rst && (free >= CW'(2) || (free >= CW'(1) && !bus.in0_valid));
        // writes to x0 complete the handshake but never occupy a slot
        push0 = bus.in0_valid && bus.in0_ready && bus.in0_rd != '0;
        push1 = bus.in1_valid && bus.in1_ready && bus.in1_rd != '0;
        npush = {1'b0, push0} + {1'b0, push1};
        pop = count_q != '0;
        rd_d = rd_q;
        wd_d = wd_q;
        if (push0) begin
            rd_d[wptr_q] = bus.in0_rd;
            wd_d[wptr_q] = bus.in0_wd;
        end
        // lane 1 lands behind lane 0 when both push, keeping program order
        if (push1) begin
            rd_d[wptr_q + AW'(push0)] = bus.in1_rd;
            wd_d[wptr_q + AW'(push0)] = bus.in1_wd;
        end
        wptr_d = wptr_q + AW'(npush);
        rptr_d = rptr_q + AW'(pop);
        count_d = count_q + CW'(npush) - CW'(pop);
        bus.wr_en = pop;
        bus.wr_rd = pop ? rd_q[rptr_q] : '0;
        bus.wr_wd = pop ? wd_q[rptr_q] : '0;
        bus.byp_hit1 = 1'b0;
        bus.byp_hit2 = 1'b0;
        bus.byp_data1 = '0;
        bus.byp_data2 = '0;
        idx = '0;
        // scan oldest to youngest so the youngest matching entry wins
        for (int k = 0; k < DEPTH; k++) begin
            idx = rptr_q + AW'(k);
            if (CW'(k) < count_q) begin
                if (bus.byp_rs1 != '0 && rd_q[idx] == bus.byp_rs1) begin
                    bus.byp_hit1 = 1'b1;
                    bus.byp_data1 = wd_q[idx];
                end
                if (bus.byp_rs2 != '0 && rd_q[idx] == bus.byp_rs2) begin
                    bus.byp_hit2 = 1'b1;
                    bus.byp_data2 = wd_q[idx];
                end
            end
        end
        bus.count = count_q;
        bus.full = count_q == CW'(DEPTH);
        bus.empty = count_q == '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
        rd_q <= rd_d;
        wd_q <= wd_d;
    end
endmodule

// File: tb/tb_wb_merge.sv
// tb_wb_merge: directed vector table plus randomized traffic against a queue-based reference of wb_merge
module tb_wb_merge;
    localparam int RS = 5, RD = 32, DEPTH = 4, CW = $clog2(DEPTH) + 1, NV = 21;

    typedef struct {
        logic rst, v0; logic [RS-1:0] rd0; logic [RD-1:0] wd0;
        logic v1; logic [RS-1:0] rd1; logic [RD-1:0] wd1;
        logic [RS-1:0] rs1, rs2;
        logic r0, r1, we; logic [RS-1:0] wrd; logic [RD-1:0] wwd;
        logic h1; logic [RD-1:0] d1; logic h2; logic [RD-1:0] d2; logic [CW-1:0] cnt;
    } vec_t;
    typedef struct packed { logic [RS-1:0] rd; logic [RD-1:0] wd; } ent_t;

    logic clk = 0, rst = 0;
    always #5 clk = ~clk;

    wb_merge_if #(.RS(RS), .RD(RD), .DEPTH(DEPTH)) bus ();
    wb_merge #(.RS(RS), .RD(RD), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0, errors = 0;
    vec_t tbl [NV];
    ent_t mq [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [RS-1:0] rd0, input logic [RD-1:0] wd0,
                         input logic v1, input logic [RS-1:0] rd1, input logic [RD-1:0] wd1,
                         input logic [RS-1:0] rs1, input logic [RS-1:0] rs2);
        bus.in0_valid = v0; bus.in0_rd = rd0; bus.in0_wd = wd0;
        bus.in1_valid = v1; bus.in1_rd = rd1; bus.in1_wd = wd1;
        bus.byp_rs1 = rs1; bus.byp_rs2 = rs2;
    endtask

    initial begin
        int sz, free;
        logic e0, e1, f0, f1, h1, h2;
        logic [RD-1:0] d1, d2;
        // rst, v0,rd0,wd0, v1,rd1,wd1, rs1,rs2 | r0,r1, we,wrd,wwd, h1,d1, h2,d2, cnt
        tbl[0]  = '{1, 1, 5, 'hDEADBEEF, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 5, 0,  1, 1, 1, 5, 'hDEADBEEF, 1, 'hDEADBEEF, 0, 0, 1};
        tbl[2]  = '{1, 1, 3, 'h11, 1, 3, 'h22, 5, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 0, 0, 0, 3, 0,  1, 1, 1, 3, 'h11, 1, 'h22, 0, 0, 2};
        tbl[4]  = '{1, 1, 0, 'hFFFF, 1, 7, 'h7, 3, 0,  1, 1, 1, 3, 'h22, 1, 'h22, 0, 0, 1};
        tbl[5]  = '{1, 0, 0, 0, 0, 0, 0, 7, 0,  1, 1, 1, 7, 'h7, 1, 'h7, 0, 0, 1};
        tbl[6]  = '{1, 0, 0, 0, 0, 0, 0, 7, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 1, 1, 'hA, 1, 2, 'hB, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 1, 4, 'hC, 1, 5, 'h5C, 2, 1,  1, 1, 1, 1, 'hA, 1, 'hB, 1, 'hA, 2};
        tbl[9]  = '{1, 0, 0, 0, 1, 6, 'hD, 4, 2,  1, 1, 1, 2, 'hB, 1, 'hC, 1, 'hB, 3};
        tbl[10] = '{1, 1, 8, 'hE, 1, 9, 'hF, 6, 5,  1, 0, 1, 4, 'hC, 1, 'hD, 1, 'h5C, 3};
        tbl[11] = '{1, 0, 0, 0, 1, 9, 'hF, 8, 9,  1, 1, 1, 5, 'h5C, 1, 'hE, 0, 0, 3};
        tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 9, 0,  1, 1, 1, 6, 'hD, 1, 'hF, 0, 0, 3};
        tbl[13] = '{1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 8, 'hE, 0, 0, 0, 0, 2};
        tbl[14] = '{1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 9, 'hF, 0, 0, 0, 0, 1};
        tbl[15] = '{1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[16] = '{1, 1, 10, 'h10, 1, 11, 'h11, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[17] = '{1, 1, 12, 'h12, 1, 13, 'h13, 0, 0,  1, 1, 1, 10, 'h10, 0, 0, 0, 0, 2};
        tbl[18] = '{0, 1, 14, 'h14, 0, 0, 0, 12, 0,  0, 0, 1, 11, 'h11, 1, 'h12, 0, 0, 3};
        tbl[19] = '{1, 0, 0, 0, 0, 0, 0, 12, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[20] = '{1, 0, 0, 0, 0, 0, 0, 13, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0};

        rst = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset count", bus.count, 0);
        chk("reset wr_en", bus.wr_en, 0);
        chk("reset empty", bus.empty, 1);
        chk("reset full", bus.full, 0);
        chk("reset in0_ready", bus.in0_ready, 0);
        chk("reset in1_ready", bus.in1_ready, 0);
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst;
            drive(tbl[i].v0, tbl[i].rd0, tbl[i].wd0, tbl[i].v1, tbl[i].rd1, tbl[i].wd1,
                  tbl[i].rs1, tbl[i].rs2);
            @(negedge clk);
            chk($sformatf("v%0d in0_ready", i), bus.in0_ready, tbl[i].r0);
            chk($sformatf("v%0d in1_ready", i), bus.in1_ready, tbl[i].r1);
            chk($sformatf("v%0d wr_en", i), bus.wr_en, tbl[i].we);
            chk($sformatf("v%0d wr_rd", i), bus.wr_rd, tbl[i].wrd);
            chk($sformatf("v%0d wr_wd", i), bus.wr_wd, tbl[i].wwd);
            chk($sformatf("v%0d byp_hit1", i), bus.byp_hit1, tbl[i].h1);
            chk($sformatf("v%0d byp_data1", i), bus.byp_data1, tbl[i].d1);
            chk($sformatf("v%0d byp_hit2", i), bus.byp_hit2, tbl[i].h2);
            chk($sformatf("v%0d byp_data2", i), bus.byp_data2, tbl[i].d2);
            chk($sformatf("v%0d count", i), bus.count, tbl[i].cnt);
            chk($sformatf("v%0d empty", i), bus.empty, tbl[i].cnt == 0);
            chk($sformatf("v%0d full", i), bus.full, tbl[i].cnt == CW'(DEPTH));
            @(posedge clk); #1;
        end

        rst = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1;
        mq.delete();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            sz = mq.size();
            free = DEPTH - sz;
            e0 = rst && free >= 1;
            e1 = rst && (free >= 2 || (free >= 1 && !bus.in0_valid));
            h1 = 0; h2 = 0; d1 = 0; d2 = 0;
            for (int i = 0; i < sz; i++) begin
                if (bus.byp_rs1 != 0 && mq[i].rd == bus.byp_rs1) begin h1 = 1; d1 = mq[i].wd; end
                if (bus.byp_rs2 != 0 && mq[i].rd == bus.byp_rs2) begin h2 = 1; d2 = mq[i].wd; end
            end
            chk("rnd in0_ready", bus.in0_ready, e0);
            chk("rnd in1_ready", bus.in1_ready, e1);
            chk("rnd wr_en", bus.wr_en, sz > 0);
            chk("rnd wr_rd", bus.wr_rd, sz > 0 ? mq[0].rd : 0);
            chk("rnd wr_wd", bus.wr_wd, sz > 0 ? mq[0].wd : 0);
            chk("rnd byp_hit1", bus.byp_hit1, h1);
            chk("rnd byp_data1", bus.byp_data1, d1);
            chk("rnd byp_hit2", bus.byp_hit2, h2);
            chk("rnd byp_data2", bus.byp_data2, d2);
            chk("rnd count", bus.count, sz);
            chk("rnd full", bus.full, sz == DEPTH);
            chk("rnd empty", bus.empty, sz == 0);
            f0 = bus.in0_valid && e0;
            f1 = bus.in1_valid && e1;
            @(posedge clk); #1;
            if (!rst) mq.delete();
            else begin
                if (sz > 0) void'(mq.pop_front());
                if (f0 && bus.in0_rd != 0) mq.push_back('{bus.in0_rd, bus.in0_wd});
                if (f1 && bus.in1_rd != 0) mq.push_back('{bus.in1_rd, bus.in1_wd});
            end
            // producers hold unaccepted data; fresh data only after a fire or an idle cycle
            if (!bus.in0_valid || f0) begin
                bus.in0_valid = $urandom_range(0, 3) != 0;
                bus.in0_rd = RS'($urandom_range(0, 7));
                bus.in0_wd = $urandom;
            end
            if (!bus.in1_valid || f1) begin
                bus.in1_valid = $urandom_range(0, 3) != 0;
                bus.in1_rd = RS'($urandom_range(0, 7));
                bus.in1_wd = $urandom;
            end
            bus.byp_rs1 = RS'($urandom_range(0, 7));
            bus.byp_rs2 = RS'($urandom_range(0, 7));
            rst = $urandom_range(0, 49) != 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
